io_mmio_uart_ctrl: RTL and testbench
====================================

Name: io_mmio_uart_ctrl

Overview:
- Memory-mapped I/O stage between the Riscv151 data-memory path and the uart_receiver / uart_transmitter pair.
- The CPU address decoder routes I/O accesses (addr[31:28] == 4'h8) here, using offset addr[7:0].
- Buffers UART bytes in RX/TX FIFOs, exposes status and data registers, and keeps 32-bit cycle and retired-instruction counters.
- Read data is registered, giving one-cycle latency that matches the dmem/BIOS synchronous-read timing.

Parameters:
- FIFO_DEPTH, 8, entries per RX and TX FIFO; power of two, 2..64.
- FIFO_AWIDTH, $clog2(FIFO_DEPTH), FIFO pointer width.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  reset; asynchronous, active-high.
- io_addr  in  8  byte offset within the I/O region; only [7:2] are decoded.
- io_re  in  1  read strobe, one cycle per access.
- io_we  in  4  write-byte-enable; any bit set means a write.
- io_wdata  in  32  write data.
- io_rdata  out  32  read data, valid the cycle after io_re.
- inst_retire  in  1  pulse per retired instruction.
- rx_data  in  8  byte from uart_receiver.
- rx_valid  in  1  uart_receiver data_out_valid.
- rx_ready  out  1  to uart_receiver data_out_ready.
- tx_data  out  8  byte to uart_transmitter.
- tx_valid  out  1  to uart_transmitter data_in_valid.
- tx_ready  in  1  uart_transmitter data_in_ready.

Behaviour:
- Reset: io_rdata=0, rx_ready=0 while rst is high then 1 (RX FIFO empty), tx_valid=0, tx_data=0, both FIFOs empty, both counters 0.
- Register map:
  - 0x00 STATUS (RO): bit0 = TX FIFO not full; bit1 = RX FIFO not empty; others 0.
  - 0x04 RX_DATA (RO): {24'b0, head byte}; the read pops the RX FIFO.
  - 0x08 TX_DATA (WO): a write with io_we[0]=1 pushes io_wdata[7:0].
  - 0x10 CYCLE (RO); 0x14 INSTRET (RO).
  - 0x18 CNT_RST (WO): any write clears both counters.
- Unmapped reads, and reads of WO registers, return 0. Writes to RO or unmapped offsets are ignored.
- Read timing: io_rdata updates on the clock edge after io_re and holds until the next io_re. The RX pop happens on the io_re cycle.
- RX_DATA read while RX FIFO is empty: returns 0, no pop, pointers unchanged.
- RX path:
  - rx_ready = !rx_full.
  - Push on rx_valid && rx_ready.
  - Full RX FIFO with a same-cycle CPU pop: rx_ready stays 0 that cycle (registered full flag); the push is accepted the next cycle.
  - Simultaneous push and pop on a non-empty, non-full FIFO: occupancy unchanged.
- TX path:
  - tx_valid = !tx_empty; tx_data = FIFO head (show-ahead).
  - Pop on tx_valid && tx_ready.
  - A TX_DATA write while full is dropped silently; software must poll STATUS bit0.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are resolved with an extra pointer MSB.
- Counters:
  - CYCLE increments every cycle; INSTRET increments when inst_retire=1.
  - Both wrap from 0xFFFF_FFFF to 0.
  - A CNT_RST write beats a same-cycle increment: value is 0 after the edge, and counting resumes the next cycle.
- Asserting rst mid-transfer empties the FIFOs immediately (async). In-flight UART bytes are lost.

Optional Feature:
- Macro IO_UART_FIFO_EN.
- Defined: RX and TX buffers are FIFO_DEPTH-entry FIFOs as described above.
- Undefined: each buffer is a single-byte holding register with a valid bit (depth 1); FIFO_DEPTH is ignored. STATUS and the register map are unchanged, full == valid.

Decomposition:
- Package io_mmio_pkg holds:
  - Offset localparams: IO_STATUS=8'h00, IO_RX_DATA=8'h04, IO_TX_DATA=8'h08, IO_CYCLE=8'h10, IO_INSTRET=8'h14, IO_CNT_RST=8'h18.
  - STATUS bit indices.
- Sub-module io_byte_fifo (WIDTH=8, DEPTH): push/pop/full/empty/dout, instantiated twice; its depth-1 form is selected by the macro.

Test Plan:
- Reset, then read 0x00 -> io_rdata=0x1 next cycle (TX not full, RX empty); tx_valid=0; rx_ready=1.
- Receive bytes 0x41, 0x42; read 0x00 -> 0x3. Read 0x04 twice -> 0x41, then 0x42. Read 0x00 -> 0x1. A third RX_DATA read -> 0 with no pointer change.
- Hold tx_ready=0 and write 0x55 nine times with FIFO_DEPTH=8 -> STATUS bit0=0 after 8 writes, ninth byte dropped. Then release tx_ready -> exactly 8 bytes of 0x55 leave; tx_valid drops after the last.
- Drive rx_valid continuously with 0x00..0x09 and no reads -> rx_ready falls after 8 bytes. Pop one -> next byte 0x08 is accepted a cycle later; order is preserved.
- Run 100 cycles with inst_retire high every other cycle -> CYCLE≈100 and INSTRET=50. Write 0x18 -> both read 0 the next access. Preload CYCLE to 0xFFFF_FFFF via force -> wraps to 0.
- Assert rst asynchronously mid-stream with 3 bytes queued -> tx_valid=0 and FIFOs empty immediately. STATUS=0x1 after release.

Source files
------------

// File: rtl/io_mmio_pkg.sv
// io_mmio_pkg: shared constants for the UART MMIO block.
//   - Register byte offsets within the I/O region (only [7:2] decoded).
//   - STATUS register bit positions.
//   - io_word(): offset -> decoded word index.
package io_mmio_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [7:0] IO_STATUS  = 8'h00;
    localparam logic [7:0] IO_RX_DATA = 8'h04;
    localparam logic [7:0] IO_TX_DATA = 8'h08;
    localparam logic [7:0] IO_CYCLE   = 8'h10;
    localparam logic [7:0] IO_INSTRET = 8'h14;
    localparam logic [7:0] IO_CNT_RST = 8'h18;

    localparam int unsigned STATUS_TX_NOT_FULL  = 0;
    localparam int unsigned STATUS_RX_NOT_EMPTY = 1;

    // Word index used for decode; byte lanes within a word alias.
    function automatic logic [5:0] io_word(input logic [7:0] off);
        return 6'(off >> 2);
    endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// io_byte_fifo: show-ahead byte buffer used for the UART RX and TX paths.
// Build option: IO_UART_FIFO_EN defined   -> DEPTH-entry circular FIFO.
//               IO_UART_FIFO_EN undefined -> single holding register (depth 1).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_push, i_din write request and data (ignored when full)
//   i_pop         read request (ignored when empty)
//   o_full        no room for another entry
//   o_empty       nothing buffered
//   o_dout        head entry, 0 when empty
module io_byte_fifo #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_dout
);

    // Elaboration guard on the configured depth.
    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || AWIDTH != $clog2(DEPTH))
    begin : g_bad_depth
        $error("io_byte_fifo: DEPTH must be a power of two in 2..64");
    end

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

`ifdef IO_UART_FIFO_EN
    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AWIDTH:0]  r_wptr;
    logic [AWIDTH:0]  r_rptr;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AWIDTH] != r_rptr[AWIDTH]) &&
                     (r_wptr[AWIDTH-1:0] == r_rptr[AWIDTH-1:0]);
    assign o_dout  = o_empty ? '0 : r_mem[r_rptr[AWIDTH-1:0]];

    // Pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AWIDTH+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AWIDTH+1)'(1);
        end
    end

    // Storage; contents need no reset because o_dout is masked when empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AWIDTH-1:0]] <= i_din;
    end
`else
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_full  = r_valid;
    assign o_empty = !r_valid;
    assign o_dout  = r_valid ? r_data : '0;

    // Push only when empty and pop only when valid, so they never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_do_pop) begin
            r_valid <= 1'b0;
        end else if (w_do_push) begin
            r_valid <= 1'b1;
            r_data  <= i_din;
        end
    end
`endif

endmodule

// File: rtl/io_mmio_uart_ctrl.sv
// io_mmio_uart_ctrl: memory-mapped UART buffers plus cycle/instret counters.
// Build option: IO_UART_FIFO_EN selects FIFO_DEPTH-entry buffers; otherwise
// each direction uses a single holding register.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   io_addr/io_re/io_we/io_wdata  CPU access (offset, read strobe, byte enables, data)
//   io_rdata            registered read data, valid the cycle after io_re
//   inst_retire         one pulse per retired instruction
//   rx_data/rx_valid/rx_ready     byte stream from uart_receiver
//   tx_data/tx_valid/tx_ready     byte stream to uart_transmitter
import io_mmio_pkg::*;

module io_mmio_uart_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        io_addr,
    input  logic              io_re,
    input  logic [3:0]        io_we,
    input  logic [WORD_W-1:0] io_wdata,
    output logic [WORD_W-1:0] io_rdata,
    input  logic              inst_retire,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned FIFO_AWIDTH = $clog2(FIFO_DEPTH);

    localparam logic [5:0] WD_STATUS  = io_word(IO_STATUS);
    localparam logic [5:0] WD_RX_DATA = io_word(IO_RX_DATA);
    localparam logic [5:0] WD_TX_DATA = io_word(IO_TX_DATA);
    localparam logic [5:0] WD_CYCLE   = io_word(IO_CYCLE);
    localparam logic [5:0] WD_INSTRET = io_word(IO_INSTRET);
    localparam logic [5:0] WD_CNT_RST = io_word(IO_CNT_RST);

    logic [5:0]        w_word;
    logic              w_is_wr;
    logic              w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
    logic              w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
    logic              w_cnt_clr;
    logic [BYTE_W-1:0] w_rx_dout;
    logic [BYTE_W-1:0] w_tx_dout;
    logic [WORD_W-1:0] w_rd_mux;
    logic [WORD_W-1:0] r_cycle;
    logic [WORD_W-1:0] r_instret;
    logic              w_unused;

    assign w_word    = io_word(io_addr);
    assign w_is_wr   = |io_we;
    assign w_cnt_clr = w_is_wr && (w_word == WD_CNT_RST);
    assign w_unused  = ^io_wdata[WORD_W-1:BYTE_W];

    // RX: ready follows the registered full flag, so a pop frees a slot next cycle.
    assign rx_ready  = !w_rx_full && !rst;
    assign w_rx_push = rx_valid && rx_ready;
    assign w_rx_pop  = io_re && (w_word == WD_RX_DATA) && !w_rx_empty;

    // TX: only byte lane 0 carries data; writes while full are dropped in the buffer.
    assign w_tx_push = io_we[0] && (w_word == WD_TX_DATA);
    assign tx_valid  = !w_tx_empty;
    assign tx_data   = w_tx_dout;
    assign w_tx_pop  = tx_valid && tx_ready;

    io_byte_fifo #(
        .WIDTH  (BYTE_W),
        .DEPTH  (FIFO_DEPTH),
        .AWIDTH (FIFO_AWIDTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_din   (rx_data),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_dout  (w_rx_dout)
    );

    io_byte_fifo #(
        .WIDTH  (BYTE_W),
        .DEPTH  (FIFO_DEPTH),
        .AWIDTH (FIFO_AWIDTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_din   (io_wdata[BYTE_W-1:0]),
        .i_pop   (w_tx_pop),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_dout  (w_tx_dout)
    );

    // Read mux; write-only and unmapped offsets read as zero.
    always_comb begin
        w_rd_mux = '0;
        case (w_word)
            WD_STATUS: begin
                w_rd_mux[STATUS_TX_NOT_FULL]  = !w_tx_full;
                w_rd_mux[STATUS_RX_NOT_EMPTY] = !w_rx_empty;
            end
            WD_RX_DATA: w_rd_mux = WORD_W'(w_rx_dout);
            WD_CYCLE:   w_rd_mux = r_cycle;
            WD_INSTRET: w_rd_mux = r_instret;
            default:    w_rd_mux = '0;
        endcase
    end

    // Read data register holds until the next read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_rdata <= '0;
        end else if (io_re) begin
            io_rdata <= w_rd_mux;
        end
    end

    // Free-running counters; a clear write wins over that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else if (w_cnt_clr) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle <= r_cycle + WORD_W'(1);
            if (inst_retire) r_instret <= r_instret + WORD_W'(1);
        end
    end

endmodule

// File: tb/tb_io_mmio_uart_ctrl.sv
// tb_io_mmio_uart_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the register map and buffers.
// Buffer depth follows IO_UART_FIFO_EN (8 when defined, 1 otherwise).
import io_mmio_pkg::*;

module tb_io_mmio_uart_ctrl;

`ifdef IO_UART_FIFO_EN
    localparam int unsigned D = 8;
`else
    localparam int unsigned D = 1;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  io_addr;
    logic        io_re;
    logic [3:0]  io_we;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        inst_retire;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    io_mmio_uart_ctrl #(.FIFO_DEPTH(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .io_addr     (io_addr),
        .io_re       (io_re),
        .io_we       (io_we),
        .io_wdata    (io_wdata),
        .io_rdata    (io_rdata),
        .inst_retire (inst_retire),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] m_cycle;
    logic [31:0] m_instret;
    logic [31:0] m_rdata;
    int          m_word;
    int          m_rx_cnt;
    int          m_tx_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q.delete();
            tx_q.delete();
            m_cycle   = '0;
            m_instret = '0;
            m_rdata   = '0;
        end else begin
            m_word   = int'(io_addr) / 4;
            m_rx_cnt = rx_q.size();
            m_tx_cnt = tx_q.size();
            if (io_re) begin
                case (m_word)
                    0:       m_rdata = ((m_tx_cnt < int'(D)) ? 32'd1 : 32'd0) +
                                       ((m_rx_cnt > 0) ? 32'd2 : 32'd0);
                    1:       m_rdata = (m_rx_cnt > 0) ? 32'(rx_q[0]) : 32'd0;
                    4:       m_rdata = m_cycle;
                    5:       m_rdata = m_instret;
                    default: m_rdata = 32'd0;
                endcase
            end
            if (io_re && m_word == 1 && m_rx_cnt > 0) void'(rx_q.pop_front());
            if (rx_valid && m_rx_cnt < int'(D)) rx_q.push_back(rx_data);
            if (m_tx_cnt > 0 && tx_ready) void'(tx_q.pop_front());
            if (io_we[0] && m_word == 2 && m_tx_cnt < int'(D)) tx_q.push_back(io_wdata[7:0]);
            if (io_we != 4'h0 && m_word == 6) begin
                m_cycle   = '0;
                m_instret = '0;
            end else begin
                m_cycle   = m_cycle + 32'd1;
                m_instret = m_instret + 32'(inst_retire);
            end
        end
    end

    // Per-cycle comparison, just after each active edge.
    always @(posedge clk) begin
        #1;
        check("rdata", io_rdata, m_rdata);
        check("rx_ready", 32'(rx_ready), (!rst && rx_q.size() < int'(D)) ? 32'd1 : 32'd0);
        check("tx_valid", 32'(tx_valid), (tx_q.size() > 0) ? 32'd1 : 32'd0);
        check("tx_data", 32'(tx_data), (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'd0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic rd(input logic [7:0] a);
        io_addr = a;
        io_re   = 1'b1;
        @(negedge clk);
        io_re   = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        io_addr  = a;
        io_we    = 4'hF;
        io_wdata = d;
        @(negedge clk);
        io_we    = 4'h0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50 && !rx_ready; i++) @(negedge clk);
        check("rx_accept", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int nxt;
        rst = 1'b1;
        io_addr = '0; io_re = 1'b0; io_we = '0; io_wdata = '0;
        inst_retire = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rdata", io_rdata, 32'h0);
        check("reset_rx_ready", 32'(rx_ready), 32'd0);
        check("reset_tx_valid", 32'(tx_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_rx_ready", 32'(rx_ready), 32'd1);

        // STATUS and RX read-out.
        rd(IO_STATUS);  check("status_idle", io_rdata, 32'h1);
        send_rx(8'h41);
        rd(IO_STATUS);  check("status_rx", io_rdata, 32'h3);
        rd(IO_RX_DATA); check("rx_byte", io_rdata, 32'h41);
        rd(IO_STATUS);  check("status_drained", io_rdata, 32'h1);
        rd(IO_RX_DATA); check("rx_empty_read", io_rdata, 32'h0);
        rd(IO_STATUS);  check("status_after_empty", io_rdata, 32'h1);
        rd(IO_TX_DATA); check("wo_read", io_rdata, 32'h0);

        // TX fill past capacity with the transmitter stalled, then drain.
        tx_ready = 1'b0;
        for (int i = 0; i <= int'(D); i++) wr(IO_TX_DATA, 32'h0000_0055);
        rd(IO_STATUS);  check("status_tx_full", io_rdata, 32'h0);
        check("tx_head", 32'(tx_data), 32'h55);
        tx_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx_valid) cnt++;
            @(negedge clk);
        end
        check("tx_sent_count", 32'(cnt), 32'(D));
        check("tx_idle", 32'(tx_valid), 32'd0);

        // RX streaming until backpressure, then pop one and drain.
        nxt = 0;
        for (int i = 0; i < 40 && nxt < 10; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(nxt);
            if (!rx_ready) break;
            @(negedge clk);
            nxt++;
        end
        check("rx_fill_count", 32'(nxt), 32'(D));
        check("rx_full_ready", 32'(rx_ready), 32'd0);
        io_addr = IO_RX_DATA; io_re = 1'b1;
        @(negedge clk);
        io_re = 1'b0;
        check("rx_pop_full", io_rdata, 32'h0);
        check("rx_ready_after_pop", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        for (int k = 1; k <= int'(D); k++) begin
            rd(IO_RX_DATA);
            check("rx_order", io_rdata, 32'(k));
        end
        rd(IO_RX_DATA); check("rx_drained", io_rdata, 32'h0);

        // Counters.
        wr(IO_CNT_RST, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i % 2 == 0);
            @(negedge clk);
        end
        inst_retire = 1'b0;
        rd(IO_CYCLE);   check("cycle_100", io_rdata, 32'd100);
        rd(IO_INSTRET); check("instret_50", io_rdata, 32'd50);
        wr(IO_CNT_RST, 32'h0);
        rd(IO_CYCLE);   check("cycle_cleared", io_rdata, 32'd0);
        rd(IO_INSTRET); check("instret_cleared", io_rdata, 32'd0);

        // Cycle counter wrap.
        force u_dut.r_cycle = 32'hFFFF_FFFF;
        #1;
        release u_dut.r_cycle;
        m_cycle = 32'hFFFF_FFFF;
        io_addr = IO_CYCLE; io_re = 1'b1;
        @(negedge clk);
        check("cycle_max", io_rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        io_re = 1'b0;
        check("cycle_wrap", io_rdata, 32'h0);

        // Asynchronous reset with bytes queued.
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(IO_TX_DATA, 32'(8'hA0 + i));
        send_rx(8'h77);
        #2;
        rst = 1'b1;
        #1;
        check("async_tx_valid", 32'(tx_valid), 32'd0);
        check("async_rx_ready", 32'(rx_ready), 32'd0);
        check("async_rdata", io_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(IO_STATUS); check("status_after_rst", io_rdata, 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            io_re       = ($urandom_range(0, 2) == 0);
            io_addr     = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                        : 8'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            io_we       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            io_wdata    = $urandom;
            rx_valid    = ($urandom_range(0, 1) == 0);
            rx_data     = 8'($urandom);
            tx_ready    = ($urandom_range(0, 2) != 0);
            inst_retire = ($urandom_range(0, 1) == 0);
            @(negedge clk);
        end
        io_re = 1'b0; io_we = '0; rx_valid = 1'b0; inst_retire = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
